imm_extend_stage: RTL

Parametrised, pipelined immediate extender for the CPU datapath, sitting between instruction decode and the ALU/branch-target operand mux. It widens an IN_W-bit immediate to OUT_W bits in one of four modes (sign, zero, upper-load, shifted branch offset) and registers the result behind a valid/ready handshake. A two-entry skid buffer lets decode keep issuing while execute stalls.

---
 rtl/imm_extend_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imm_extend_stage.sv
// Pipelined immediate extender (sign/zero/upper/branch) behind a valid/ready handshake.
// Define IMM_EXT_SKID_EN to add the skid register and a registered in_ready_o.
module imm_extend_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [IN_W-1:0]  data_i,
   input  logic [1:0]       mode_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] data_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_SIGN   = 2'b00;
   localparam logic [1:0] MODE_ZERO   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   logic [OUT_W-1:0] sext_val;
   logic [OUT_W-1:0] zext_val;
   logic [OUT_W-1:0] upper_val;
   logic [OUT_W-1:0] branch_val;
   logic [OUT_W-1:0] ext_val;

   state_t           state_reg;
   state_t           state_next;
   logic [OUT_W-1:0] main_reg;
   logic [OUT_W-1:0] main_next;
   logic             in_xfer;
   logic             out_xfer;

   // Per-bit construction keeps the IN_W == OUT_W case free of zero-width replications.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_ext
         if (gi < IN_W) begin : g_low
            assign sext_val[gi] = data_i[gi];
            assign zext_val[gi] = data_i[gi];
         end else begin : g_high
            assign sext_val[gi] = data_i[IN_W-1];
            assign zext_val[gi] = 1'b0;
         end
         if (gi >= OUT_W - IN_W) begin : g_up
            assign upper_val[gi] = data_i[gi-(OUT_W-IN_W)];
         end else begin : g_up_zero
            assign upper_val[gi] = 1'b0;
         end
      end
   endgenerate

   assign branch_val = sext_val << SHIFT;

   always_comb begin
      ext_val = sext_val;
      case (mode_i)
         MODE_SIGN:   ext_val = sext_val;
         MODE_ZERO:   ext_val = zext_val;
         MODE_UPPER:  ext_val = upper_val;
         MODE_BRANCH: ext_val = branch_val;
         default:     ext_val = sext_val;
      endcase
   end

   assign out_valid_o = (state_reg != ST_EMPTY);
   assign data_o      = main_reg;
   assign in_xfer     = in_valid_i && in_ready_o;
   assign out_xfer    = out_valid_o && out_ready_i;

`ifdef IMM_EXT_SKID_EN
   logic [OUT_W-1:0] skid_reg;
   logic [OUT_W-1:0] skid_next;
   logic             in_ready_reg;

   // Ready comes straight from a flop, so out_ready_i never reaches in_ready_o.
   assign in_ready_o = in_ready_reg;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_next  = ext_val;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               main_next = ext_val;
            end else if (in_xfer) begin
               skid_next  = ext_val;
               state_next = ST_FULL;
            end else if (out_xfer) begin
               state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               main_next  = skid_reg;
               state_next = ST_ONE;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= ST_EMPTY;
         main_reg     <= '0;
         skid_reg     <= '0;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         main_reg     <= main_next;
         skid_reg     <= skid_next;
         in_ready_reg <= (state_next != ST_FULL);
      end
   end
`else
   // Without a skid slot, accept only when the main register is free or draining now.
   assign in_ready_o = !out_valid_o || out_ready_i;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_next  = ext_val;
               state_next = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer) begin
               main_next = ext_val;
            end else if (out_xfer) begin
               state_next = ST_EMPTY;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= ST_EMPTY;
         main_reg  <= '0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
      end
   end
`endif

endmodule
